// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display scheduler: FSM states, blank code and
// sign-magnitude normalisation.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    StOff,
    StShowBase,
    StBlank,
    StShowTemp
  } state_e;

  localparam logic [8:0] BlankVal = 9'h000;

  // Negative zero would light a lone minus sign, so fold it onto plain zero.
  function automatic logic [8:0] normalise(input logic [8:0] v);
    if (v[8] && (v[7:0] == 8'd0)) begin
      return BlankVal;
    end
    return v;
  endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter that parks at zero; zero flag marks the last cycle of a phase.
module disp_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// Shares one 3-digit 7-segment decoder between a base source and temporary sources
// that request display time through a req/ack handshake.
module display_scheduler
  import disp_sched_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned BLANK_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               power_on,
  input  logic [9*N_REQ-1:0] vals,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   ack,
  output logic [8:0]         disp_val,
  output logic               disp_en,
  output logic [1:0]         disp_src,
  output logic               busy
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int unsigned TimerW    = ($clog2(MaxCycles) > 0) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] HoldLoad  = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] BlankLoad = TimerW'(BLANK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [8:0]        hold_q, hold_d;
  logic [1:0]        idx_q, idx_d;
  logic [N_REQ-1:0]  grant;
  logic              take;
  logic              preempt, same;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic [8:0]        win_val;
  logic [8:0]        base_val;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TimerW-1:0] tmr_val;
  logic [8:0]        disp_val_d;
  logic              disp_en_d, busy_d;
  logic [1:0]        disp_src_d;
  logic              unused_req0;

  assign unused_req0 = req[0];
  assign base_val    = normalise(vals[8:0]);

  // Fixed priority: scan downwards so the lowest requesting index >= 1 ends up winning.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    win_val   = BlankVal;
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_idx   = 2'(i);
        win_val   = normalise(vals[9*i +: 9]);
      end
    end
  end

  assign preempt = win_valid && (win_idx < idx_q);
  assign same    = win_valid && (win_idx == idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StOff;
      hold_q   <= BlankVal;
      idx_q    <= 2'd0;
      disp_val <= BlankVal;
      disp_en  <= 1'b0;
      disp_src <= 2'd0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      disp_val <= disp_val_d;
      disp_en  <= disp_en_d;
      disp_src <= disp_src_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    take     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!power_on) begin
      // Power loss beats every request and expiry and drops whatever was held.
      state_d  = StOff;
      hold_d   = BlankVal;
      idx_d    = 2'd0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        StOff: state_d = StShowBase;
        StShowBase: begin
          if (win_valid) begin
            take     = 1'b1;
            state_d  = StBlank;
            tmr_load = 1'b1;
            tmr_val  = BlankLoad;
          end
        end
        StBlank: begin
          if (preempt) begin
            take     = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = BlankLoad;
          end else begin
            take = same;
            if (tmr_zero) begin
              state_d  = StShowTemp;
              tmr_load = 1'b1;
              tmr_val  = HoldLoad;
            end
          end
        end
        StShowTemp: begin
          if (preempt) begin
            take     = 1'b1;
            state_d  = StBlank;
            tmr_load = 1'b1;
            tmr_val  = BlankLoad;
          end else if (same) begin
            take     = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = HoldLoad;
          end else if (tmr_zero) begin
            state_d = StShowBase;
          end
        end
        default: state_d = StOff;
      endcase
    end
    if (take) begin
      hold_d = win_val;
      idx_d  = win_idx;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 1; i < N_REQ; i++) begin
      grant[i] = take && (win_idx == 2'(i));
    end
  end

  assign ack    = reset ? '0 : grant;
  assign tmr_en = (state_q == StBlank) || (state_q == StShowTemp);

  always_comb begin
    disp_val_d = BlankVal;
    disp_en_d  = 1'b0;
    disp_src_d = 2'd0;
    busy_d     = 1'b0;
    unique case (state_q)
      StOff: ;
      StShowBase: begin
        disp_val_d = base_val;
        disp_en_d  = 1'b1;
      end
      StBlank: begin
        disp_src_d = idx_q;
        busy_d     = 1'b1;
      end
      StShowTemp: begin
        disp_val_d = hold_q;
        disp_en_d  = 1'b1;
        disp_src_d = idx_q;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

  disp_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (tmr_en),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts each cycle's outputs, a
// negedge monitor compares them against the scheduler.
module tb_display_scheduler;

  localparam int unsigned NReq  = 3;
  localparam int unsigned Hold  = 8;
  localparam int unsigned Blank = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        power_on;
  logic [26:0] vals;
  logic [2:0]  req;
  logic [2:0]  ack;
  logic [8:0]  disp_val;
  logic        disp_en;
  logic [1:0]  disp_src;
  logic        busy;

  display_scheduler #(
    .N_REQ       (NReq),
    .HOLD_CYCLES (Hold),
    .BLANK_CYCLES(Blank)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .power_on(power_on),
    .vals    (vals),
    .req     (req),
    .ack     (ack),
    .disp_val(disp_val),
    .disp_en (disp_en),
    .disp_src(disp_src),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ack;
    logic       en;
    logic [8:0] val;
    logic [1:0] src;
    logic       busy;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       mon_e;
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  logic [8:0] v[3];
  logic [2:0] req_r;

  // Reference model: what is on the display, how many cycles of the phase remain,
  // which source is held, and the output the display will show next cycle.
  int         mode;   // 0 dark, 1 base, 2 gap, 3 temp
  int         left;
  int         held;
  logic [8:0] held_v;
  obs_t       regs;

  function automatic logic [8:0] norm(input logic [8:0] x);
    return (x[8] && (x[7:0] == 8'd0)) ? 9'h000 : x;
  endfunction

  function automatic logic [8:0] pick();
    case ($urandom_range(0, 3))
      0:       return 9'h100;
      1:       return 9'h1FF;
      2:       return 9'h000;
      default: return 9'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ack", 9'(ack), 9'(mon_e.ack));
      check("disp_en", 9'(disp_en), 9'(mon_e.en));
      check("busy", 9'(busy), 9'(mon_e.busy));
      if (mon_e.en) begin
        check("disp_val", disp_val, mon_e.val);
        check("disp_src", 9'(disp_src), 9'(mon_e.src));
      end
    end
  end

  task automatic step(input bit p, input logic [2:0] raise, input bit rst);
    obs_t       e;
    obs_t       nxt;
    logic [2:0] a;
    int         w;
    @(posedge clk);
    #1;
    cyc++;
    req_r    = (req_r | raise) & 3'b110;
    reset    = rst;
    power_on = p;
    req      = req_r;
    vals     = {v[2], v[1], v[0]};
    a        = 3'b000;
    w        = 0;
    for (int i = 2; i >= 1; i--) if (req_r[i]) w = i;
    if (rst) begin
      e      = '0;
      exp_q.push_back(e);
      mode   = 0;
      left   = 0;
      held   = 0;
      held_v = 9'h000;
      regs   = '0;
    end else begin
      nxt = '0;
      case (mode)
        1: begin nxt.en = 1'b1; nxt.val = norm(v[0]); end
        2: begin nxt.busy = 1'b1; nxt.src = 2'(held); end
        3: begin nxt.en = 1'b1; nxt.val = held_v; nxt.src = 2'(held); nxt.busy = 1'b1; end
        default: ;
      endcase
      if (!p) begin
        mode   = 0;
        held   = 0;
        held_v = 9'h000;
      end else begin
        case (mode)
          0: mode = 1;
          1: if (w != 0) begin a[w] = 1'b1; mode = 2; left = Blank; end
          2: begin
            if (w != 0 && w < held) begin
              a[w] = 1'b1;
              left = Blank;
            end else begin
              if (w != 0 && w == held) a[w] = 1'b1;
              if (left == 1) begin mode = 3; left = Hold; end
              else left--;
            end
          end
          default: begin
            if (w != 0 && w < held) begin
              a[w] = 1'b1;
              mode = 2;
              left = Blank;
            end else if (w != 0 && w == held) begin
              a[w] = 1'b1;
              left = Hold;
            end else if (left == 1) mode = 1;
            else left--;
          end
        endcase
      end
      if (a != 3'b000) begin
        held   = w;
        held_v = norm(v[w]);
      end
      e     = regs;
      e.ack = a;
      exp_q.push_back(e);
      regs  = nxt;
    end
    req_r = req_r & ~a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 3'b000, 1'b0);
  endtask

  initial begin
    int         poff;
    bit         rs;
    logic [2:0] r;
    reset    = 1'b1;
    power_on = 1'b0;
    req      = 3'b000;
    vals     = '0;
    req_r    = 3'b000;
    v[0]     = 9'h02A;
    v[1]     = 9'h10F;
    v[2]     = 9'h033;
    poff     = 0;
    step(1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b0);
    idle(4);
    // Single temporary display, then back to base.
    step(1'b1, 3'b010, 1'b0);
    idle(12);
    // Lower priority waits behind source 1.
    step(1'b1, 3'b010, 1'b0);
    idle(3);
    step(1'b1, 3'b100, 1'b0);
    idle(14);
    // Higher priority preempts source 2.
    step(1'b1, 3'b100, 1'b0);
    idle(4);
    v[1] = 9'h0C8;
    step(1'b1, 3'b010, 1'b0);
    idle(12);
    // Retrigger exactly on the last hold cycle.
    step(1'b1, 3'b010, 1'b0);
    idle(9);
    v[1] = 9'h177;
    step(1'b1, 3'b010, 1'b0);
    idle(12);
    v[0] = 9'h100;
    idle(3);
    v[0] = 9'h1FF;
    idle(3);
    // Power drop and reset in the middle of a blank gap.
    v[1] = 9'h055;
    step(1'b1, 3'b010, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b100, 1'b0);
    idle(16);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b0);
    idle(16);
    for (int c = 0; c < 3000; c++) begin
      r = 3'b000;
      if ($urandom_range(0, 7) == 0) v[0] = pick();
      for (int i = 1; i <= 2; i++) begin
        if (!req_r[i] && ($urandom_range(0, 9) == 0)) begin
          r[i] = 1'b1;
          v[i] = pick();
        end
      end
      if (poff > 0) poff--;
      else if ($urandom_range(0, 99) == 0) poff = $urandom_range(1, 4);
      rs = ($urandom_range(0, 299) == 0);
      step(poff == 0, r, rs);
    end
    idle(2);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Controller that owns the single 3-digit sign-magnitude 7-segment decoder and shares it between several value sources of the remote-control system.
- Source 0 (channel number) is shown by default.
- Sources 1..N_REQ-1 (volume, menu value, ...) request temporary display through a req/ack handshake, are shown for a hold time after a blank gap, then the display reverts to source 0.
- Drives the decoder's 9-bit value input and enable; blanks the display when power is off.

Parameters:
N_REQ, 3, number of sources including base source 0 (min 2, max 4)
HOLD_CYCLES, 50000000, cycles a temporary value stays on display (min 1)
BLANK_CYCLES, 5000000, cycles of blank gap before a temporary value is shown (min 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
power_on  in  1  level; 0 forces display off
vals  in  9*N_REQ  source values; slice i = vals[9*i+8:9*i]; bit 8 = sign, bits 7:0 = magnitude
req  in  N_REQ  level request per source, held until ack; req[0] ignored
ack  out  N_REQ  combinational one-cycle grant; ack[0] always 0
disp_val  out  9  registered value to decoder
disp_en  out  1  registered decoder enable
disp_src  out  2  registered index of source currently shown
busy  out  1  registered; 1 in BLANK or SHOW_TEMP

Behaviour:
- Reset (async, immediate): state OFF, disp_val 0, disp_en 0, disp_src 0, busy 0, timer 0, hold register 0. ack is 0 while reset is high.
- States:
  - OFF: disp_en 0; no acks. power_on=1 -> SHOW_BASE next cycle.
  - SHOW_BASE: disp_val <= normalised vals slice 0 every cycle, so one-cycle latency from a vals change. disp_en 1, disp_src 0.
  - BLANK: disp_en 0; timer counts down from BLANK_CYCLES-1.
  - SHOW_TEMP: disp_val <= hold register; disp_en 1; disp_src = held index; timer counts down from HOLD_CYCLES-1.
- Arbitration: fixed priority; lowest index >=1 wins (req[1] highest).
  - Grant in cycle k: ack[i]=1 in cycle k; slice i is captured into the hold register and its index latched at the end of cycle k.
  - Requester drops req after the edge where ack was seen. A req still high in cycle k+1 is a new request.
- Grant rules:
  - SHOW_BASE, any req[i>=1]: grant -> BLANK.
  - BLANK or SHOW_TEMP, req from a higher-priority source than the held one: grant and preempt -> BLANK, timer reloaded.
  - SHOW_TEMP, req from the held source: grant; recapture value; stay in SHOW_TEMP; timer reloaded to HOLD_CYCLES-1 (retrigger, no blank).
  - BLANK, req from the held source: grant; recapture value; BLANK timer continues.
  - Lower-priority req: not granted; it stays pending and is served from SHOW_BASE later.
- Timer expiry:
  - BLANK with timer 0 -> SHOW_TEMP.
  - SHOW_TEMP with timer 0 and no retrigger that cycle -> SHOW_BASE.
  - Retrigger wins over expiry in the same cycle.
- power_on=0 in any state: next state OFF, hold discarded, no ack that cycle. This has priority over all requests and expiry.
- Normalisation: sign 1 with magnitude 0 becomes 9'h000 (no negative zero). Magnitude passes unchanged (0..255 fits three digits).
- Timer width: $clog2(max(HOLD_CYCLES,BLANK_CYCLES)); no wrap (it stops at 0).
- Reset mid-operation returns to OFF regardless of state; requests pending at release are re-arbitrated after power_on.

Decomposition:
- Package disp_sched_pkg: state enum (OFF, SHOW_BASE, BLANK, SHOW_TEMP), blank value 9'h000, normalise function.
- One sub-module disp_timer: loadable down-counter with load value, load strobe, and zero flag.
- Arbitration and FSM live in the top level.

Test Plan:
- Reset, then power_on=1 with vals slice0=9'h02A -> disp_en=1, disp_val=9'h02A two cycles after power_on; ack=0.
- HOLD=8, BLANK=2, req[1] pulsed with slice1=9'h10F -> ack[1] in the same cycle; disp_en 0 for 2 cycles; then 9'h10F shown for 8 cycles with disp_src=1; then slice0 returns.
- req[2] during SHOW_TEMP of source 1 -> no ack[2] until return to SHOW_BASE, then served. req[1] during SHOW_TEMP of source 2 -> immediate ack[1] and BLANK.
- Retrigger req[1] on the cycle the timer reaches 0 -> stays in SHOW_TEMP, new value shown, 8 more cycles.
- Slice0=9'h100 (negative zero) -> disp_val=9'h000. Slice0=9'h1FF -> disp_val=9'h1FF.
- power_on dropped, or reset asserted, mid-BLANK -> disp_en 0; no ack; after power_on the display shows slice0, not the discarded held value.
